// File: rtl/present_decrypt_pkg.sv
// Shared constants for the PRESENT-80 decryptor: S-box tables, round count
// and FSM state encodings.
`timescale 1ns/1ps
package present_decrypt_pkg;

  localparam int ROUNDS = 31;
  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYEXP = 3'd1,
    S_WHITEN = 3'd2,
    S_DEC    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Entry n lives in nibble n (bits 4n+3..4n) of each table.
  localparam logic [63:0] SBOX_TBL     = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] INV_SBOX_TBL = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/present_decrypt_if.sv
// Request/response bundle of the PRESENT-80 decryptor.
`timescale 1ns/1ps
interface present_decrypt_if;
  logic        start;
  logic [63:0] ciphertext;
  logic [79:0] key;
  logic [63:0] plaintext;
  logic        busy;
  logic        done;

  modport master (output start, ciphertext, key, input plaintext, busy, done);
  modport slave  (input start, ciphertext, key, output plaintext, busy, done);
endinterface

// File: rtl/present_decrypt_inv_round.sv
// One combinational PRESENT decryption round: inverse pLayer, inverse S-box
// on all nibbles, then round-key XOR.
`timescale 1ns/1ps
module present_inv_round
  import present_decrypt_pkg::*;
(
  input  logic [63:0] state_i,
  input  logic [63:0] round_key_i,
  output logic [63:0] state_o
);

  logic [63:0] perm;
  logic [63:0] subst;

  genvar gi;
  generate
    // Forward pLayer moves bit i to 16*(i%4)+i/4; undo it.
    for (gi = 0; gi < 64; gi++) begin : g_perm
      assign perm[gi] = state_i[16 * (gi % 4) + gi / 4];
    end
    for (gi = 0; gi < 16; gi++) begin : g_sbox
      assign subst[4 * gi +: 4] = inv_sbox(perm[4 * gi +: 4]);
    end
  endgenerate

  assign state_o = subst ^ round_key_i;

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryptor: expands the user key forward to K32, then
// walks the schedule backwards while undoing one round per cycle.
`timescale 1ns/1ps
module present_decrypt
  import present_decrypt_pkg::*;
(
  input logic         clk,
  input logic         rst,
  present_decrypt_if.slave bus
);

  state_e      fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] pt_q, pt_d;

  logic [79:0] key_rot;
  logic [79:0] key_fwd;
  logic [79:0] key_x;
  logic [79:0] key_inv;
  logic [63:0] round_out;

  // Forward schedule step: rotate left 61, S-box top nibble, XOR counter.
  always_comb begin
    key_rot         = {key_q[18:0], key_q[79:19]};
    key_fwd         = {sbox(key_rot[79:76]), key_rot[75:0]};
    key_fwd[19:15]  = key_rot[19:15] ^ cnt_q;
  end

  // Exact inverse of the forward step, applied in reverse order.
  always_comb begin
    key_x         = key_q;
    key_x[19:15]  = key_q[19:15] ^ cnt_q;
    key_x[79:76]  = inv_sbox(key_q[79:76]);
    key_inv       = {key_x[60:0], key_x[79:61]};
  end

  present_inv_round u_inv_round (
    .state_i     (state_q),
    .round_key_i (key_inv[79:16]),
    .state_o     (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = bus.ciphertext;
          key_d   = bus.key;
          cnt_d   = 5'd1;
          fsm_d   = S_KEYEXP;
        end
      end
      S_KEYEXP: begin
        key_d = key_fwd;
        // Counter holds at 31 so the DEC phase can start from it directly.
        if (cnt_q == LAST_ROUND) begin
          fsm_d = S_WHITEN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_WHITEN: begin
        state_d = state_q ^ key_q[79:16];
        fsm_d   = S_DEC;
      end
      S_DEC: begin
        state_d = round_out;
        key_d   = key_inv;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          pt_d  = round_out;
          fsm_d = S_DONE;
        end
      end
      S_DONE: begin
        fsm_d = S_IDLE;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      pt_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
    end
  end

  assign bus.plaintext = pt_q;
  assign bus.busy      = (fsm_q == S_KEYEXP) || (fsm_q == S_WHITEN) || (fsm_q == S_DEC);
  assign bus.done      = (fsm_q == S_DONE);

endmodule

// File: tb/tb_present_decrypt.sv
// Scoreboard bench for present_decrypt using the published PRESENT-80 vectors.
`timescale 1ns/1ps
module tb_present_decrypt;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  present_decrypt_if bus();

  present_decrypt u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] pt;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  logic [63:0] ct_tab  [4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                               64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
  logic [79:0] key_tab [4] = '{80'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF,
                               80'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
  logic [63:0] pt_tab  [4] = '{64'h0, 64'h0,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0 && bus.done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 with plaintext %h want no pending request",
                 bus.plaintext);
      end else begin
        e = sb_q.pop_front();
        check64({e.name, "_pt"}, bus.plaintext, e.pt);
        check64({e.name, "_latency"}, 64'(cyc - e.acc), 64'd64);
        check64({e.name, "_busy_at_done"}, {63'b0, bus.busy}, 64'd0);
        $display("txn %s: plaintext=%h latency=%0d", e.name, bus.plaintext, cyc - e.acc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  // Issues a one-cycle start; returns the cycle index used as the latency origin.
  task automatic send(input int idx, input string nm, input bit expect_done, output int acc);
    exp_t e;
    step();
    bus.start      = 1'b1;
    bus.ciphertext = ct_tab[idx];
    bus.key        = key_tab[idx];
    acc            = cyc;
    if (expect_done) begin
      e.pt = pt_tab[idx]; e.acc = cyc; e.name = nm;
      sb_q.push_back(e);
    end
    step();
    bus.start = 1'b0;
  endtask

  task automatic drain(input int budget, input string nm);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending results want 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int n0;
    int dc;
    exp_t e;

    rst            = 1'b1;
    bus.start      = 1'b1;
    bus.ciphertext = ct_tab[0];
    bus.key        = key_tab[0];
    repeat (3) step();
    check64("rst_plaintext", bus.plaintext, 64'h0);
    check64("rst_busy", {63'b0, bus.busy}, 64'd0);
    check64("rst_done", {63'b0, bus.done}, 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    check64("rst_over_start", {63'b0, bus.busy}, 64'd0);
    $display("txn reset: plaintext=%h busy=%b", bus.plaintext, bus.busy);

    for (int i = 0; i < 4; i++) begin
      send(i, $sformatf("vec%0d", i), 1'b1, acc);
      drain(120, $sformatf("vec%0d", i));
    end

    // Starts while busy and during DONE must be ignored.
    dc = done_cnt;
    send(2, "ignore_start", 1'b1, acc);
    wait_cyc(acc + 10);
    bus.start = 1'b1; bus.ciphertext = ct_tab[0]; bus.key = key_tab[0];
    check64("busy_at_10", {63'b0, bus.busy}, 64'd1);
    step();
    bus.start = 1'b0;
    wait_cyc(acc + 40);
    bus.start = 1'b1; bus.ciphertext = ct_tab[1]; bus.key = key_tab[1];
    step();
    bus.start = 1'b0;
    wait_cyc(acc + 64);
    check64("done_at_64", {63'b0, bus.done}, 64'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    drain(10, "ignore_start");
    check64("ignore_done_count", 64'(done_cnt - dc), 64'd1);
    check64("ignore_busy_after", {63'b0, bus.busy}, 64'd0);
    check64("ignore_pt_held", bus.plaintext, 64'hFFFF_FFFF_FFFF_FFFF);
    $display("txn ignore_start: dones=%0d plaintext=%h", done_cnt - dc, bus.plaintext);

    // Reset in the middle of DEC aborts the block.
    dc = done_cnt;
    send(0, "abort", 1'b0, acc);
    wait_cyc(acc + 45);
    check64("abort_busy_before", {63'b0, bus.busy}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check64("abort_busy", {63'b0, bus.busy}, 64'd0);
    check64("abort_done", {63'b0, bus.done}, 64'd0);
    check64("abort_plaintext", bus.plaintext, 64'h0);
    repeat (70) step();
    check64("abort_no_done", 64'(done_cnt - dc), 64'd0);
    $display("txn abort: plaintext=%h dones=%0d", bus.plaintext, done_cnt - dc);
    send(0, "after_abort", 1'b1, acc);
    drain(120, "after_abort");

    // start held high: one accept every 65 cycles, inputs changed per block.
    step();
    n0 = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_cyc(n0 + 65 * k);
      bus.start      = 1'b1;
      bus.ciphertext = ct_tab[(k + 1) % 4];
      bus.key        = key_tab[(k + 1) % 4];
      e.pt = pt_tab[(k + 1) % 4]; e.acc = cyc; e.name = $sformatf("b2b%0d", k);
      sb_q.push_back(e);
    end
    wait_cyc(n0 + 65 * 3 + 1);
    bus.start = 1'b0;
    drain(150, "b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/present_decrypt.md
PRESENT_DECRYPT -- requirements
Module: present_decrypt

Interface
REQ-001 Parameters: none; round count 31 is a fixed constant from the shared include.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 ciphertext  input  64  [0:63], bit 0 = MSB; captured when start is accepted.
REQ-006 key  input  80  [0:79], bit 0 = MSB, user key K1; captured when start is accepted.
REQ-007 plaintext  output  64  [0:63] result; registered; held until next accepted start or reset.
REQ-008 busy  output  1  high from the cycle after start is accepted through the final round cycle.
REQ-009 done  output  1  one-cycle pulse; plaintext is valid in that cycle.

Function
REQ-010 FSM states are IDLE, KEYEXP, WHITEN, DEC and DONE; rst forces IDLE from any state.
REQ-011 IDLE with start=1 at edge E0: latch ciphertext into state register, key into key register, round counter <= 1, go to KEYEXP.
REQ-012 KEYEXP, each cycle: key <= forward PRESENT-80 update (rotate left 61; S-box on bits [0:3]; bits [60:64] ^= counter); counter++.
REQ-013 After 31 KEYEXP cycles (E1..E31), the key register holds K32, counter = 31, and the FSM goes to WHITEN.
REQ-014 WHITEN, one cycle (E32): state <= state ^ key[0:63]; go to DEC.
REQ-015 DEC, each cycle: Kp = inverse key update of key with counter (bits [60:64] ^= counter; inverse S-box on bits [0:3]; rotate right 61).
REQ-016 DEC, same cycle: state <= invSbox(invPLayer(state)) ^ Kp[0:63]; key <= Kp; counter--.
REQ-017 invPLayer maps bit j of the input to bit i, where P(i)=j and P(i)=16*(i mod 4)+floor(i/4), indices counted from the LSB (bit 63 in [0:63] order).
REQ-018 Inverse S-box is {5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A}, applied to all 16 nibbles in parallel.
REQ-019 DEC performs 31 cycles (E33..E63), with counter going 31 down to 1; after E63 the key register equals K1.
REQ-020 At E63: plaintext <= decrypted state; FSM enters DONE, so done=1 and busy=0 in the cycle after E63.
REQ-021 DONE lasts one cycle, then returns to IDLE; start asserted during DONE is ignored.
REQ-022 Latency: done is asserted 64 cycles after the accepting edge; throughput is one block per 65 cycles.
REQ-023 start asserted while busy=1 is ignored; the inputs may change freely while busy.
REQ-024 The counter is 5 bits and never wraps, since its range is 1..31.

Reset
REQ-025 rst=1 at a clock edge: FSM <= IDLE, busy <= 0, done <= 0, plaintext <= 0, state <= 0, key <= 0, counter <= 0.
REQ-026 rst asserted mid-operation aborts the block: no done pulse, plaintext reads 0, and the next start restarts cleanly.
REQ-027 rst takes priority over start in the same cycle.

Structure
REQ-028 Shared include present_defs.vh holds: forward and inverse S-box tables, ROUNDS=31, and the FSM state encodings.
REQ-029 One combinational sub-module, present_inv_round, performs invPLayer, invSbox and the round-key XOR.
REQ-030 The inverse and forward key-update logic stays in present_decrypt; present_decrypt holds all registers.

Verification
REQ-031 key=0, ciphertext=5579C1387B228445, one-cycle start -> done exactly 64 cycles later with plaintext=0000000000000000.
REQ-032 key=FFFFFFFFFFFFFFFFFFFF, ciphertext=E72C46C0F5945049 -> plaintext=0000000000000000.
REQ-033 key=0, ciphertext=A112FFC72F68417B -> plaintext=FFFFFFFFFFFFFFFF; then key=all-ones, ciphertext=3333DCD3213210D2 -> plaintext=FFFFFFFFFFFFFFFF.
REQ-034 start pulsed at cycles 10 and 40 after acceptance, with changed inputs -> the result matches the first request only; done is asserted once.
REQ-035 rst pulsed during DEC at cycle 45 -> no done, plaintext=0, busy=0 next cycle; then the REQ-031 vector decrypts correctly.
REQ-036 Back-to-back requests: start held high continuously -> a done pulse every 65 cycles, each carrying the correct plaintext.
